n101_uart_icb_arbiter: RTL and testbench

//  - Shares the single ICB slave port of the UART block between two ICB masters.
//    - m0: core load/store path.
//    - m1: debug/boot-loader path.
//  - Round-robin arbitration with one outstanding transaction at a time.
//  - Routes each response back to the master that issued the command.
//  - Response-timeout watchdog: a hung slave can never lock a master.
//  - Sits between the peripheral bus fabric and the UART top.

---
 rtl/n101_uart_icb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_n101_uart_icb_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/n101_uart_icb_arbiter.sv
// Two-master ICB arbiter in front of the UART slave port.
// Round-robin grant, one outstanding transaction, response routing back to
// the issuing master, and a response watchdog that synthesises an error
// response when the slave never answers.
module n101_uart_icb_arbiter #(
  parameter int          AW      = 32,
  parameter int          TO_W    = 8,
  parameter logic [31:0] ERR_DAT = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          rst_n,
  // master 0: core load/store path
  input  logic          m0_icb_cmd_valid,
  output logic          m0_icb_cmd_ready,
  input  logic [AW-1:0] m0_icb_cmd_addr,
  input  logic          m0_icb_cmd_read,
  input  logic [31:0]   m0_icb_cmd_wdata,
  output logic          m0_icb_rsp_valid,
  input  logic          m0_icb_rsp_ready,
  output logic [31:0]   m0_icb_rsp_rdata,
  output logic          m0_icb_rsp_err,
  // master 1: debug / boot-loader path
  input  logic          m1_icb_cmd_valid,
  output logic          m1_icb_cmd_ready,
  input  logic [AW-1:0] m1_icb_cmd_addr,
  input  logic          m1_icb_cmd_read,
  input  logic [31:0]   m1_icb_cmd_wdata,
  output logic          m1_icb_rsp_valid,
  input  logic          m1_icb_rsp_ready,
  output logic [31:0]   m1_icb_rsp_rdata,
  output logic          m1_icb_rsp_err,
  // shared UART slave port
  output logic          s_icb_cmd_valid,
  input  logic          s_icb_cmd_ready,
  output logic [AW-1:0] s_icb_cmd_addr,
  output logic          s_icb_cmd_read,
  output logic [31:0]   s_icb_cmd_wdata,
  input  logic          s_icb_rsp_valid,
  output logic          s_icb_rsp_ready,
  input  logic [31:0]   s_icb_rsp_rdata
);

  typedef enum logic [1:0] {IDLE, GRANT, CMD, RSP} state_t;

  localparam logic [TO_W-1:0] TIMER_ONE = {{(TO_W-1){1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic            owner, owner_nxt;
  logic            last, last_nxt;
  logic [TO_W-1:0] timer, timer_nxt;
  logic            to_pend, to_pend_nxt;

  // owner-selected views of the two masters
  logic            own_cmd_valid;
  logic            own_rsp_ready;
  logic            rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic            cmd_ready;

  // Control state register; last resets to 1 so m0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      timer   <= '0;
      to_pend <= 1'b0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      last    <= last_nxt;
      timer   <= timer_nxt;
      to_pend <= to_pend_nxt;
    end
  end

  // Next-state logic and the owner-side command/response view.
  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    last_nxt        = last;
    timer_nxt       = timer;
    to_pend_nxt     = to_pend;
    s_icb_cmd_valid = 1'b0;
    s_icb_cmd_addr  = '0;
    s_icb_cmd_read  = 1'b0;
    s_icb_cmd_wdata = '0;
    s_icb_rsp_ready = 1'b0;
    cmd_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_rdata       = '0;
    rsp_err         = 1'b0;

    own_cmd_valid = owner ? m1_icb_cmd_valid : m0_icb_cmd_valid;
    own_rsp_ready = owner ? m1_icb_rsp_ready : m0_icb_rsp_ready;

    case (state)
      IDLE: begin
        // Under contention the master that was not served last wins.
        if (m0_icb_cmd_valid || m1_icb_cmd_valid) begin
          owner_nxt = (m0_icb_cmd_valid && m1_icb_cmd_valid) ? ~last : m1_icb_cmd_valid;
          state_nxt = GRANT;
        end
      end
      GRANT, CMD: begin
        // Only the registered owner reaches the slave; no direct request path.
        s_icb_cmd_valid = own_cmd_valid;
        s_icb_cmd_addr  = owner ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
        s_icb_cmd_read  = owner ? m1_icb_cmd_read  : m0_icb_cmd_read;
        s_icb_cmd_wdata = owner ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
        cmd_ready       = s_icb_cmd_ready;
        if (!own_cmd_valid) begin
          // Withdrawn request: back to IDLE without touching fairness history.
          state_nxt = IDLE;
        end else if (s_icb_cmd_ready) begin
          state_nxt = RSP;
          timer_nxt = '0;
        end else if (state == GRANT) begin
          state_nxt = CMD;
        end
      end
      RSP: begin
        if (to_pend) begin
          // Synthetic error response wins; any late UART response is drained.
          rsp_valid       = 1'b1;
          rsp_rdata       = ERR_DAT;
          rsp_err         = 1'b1;
          s_icb_rsp_ready = 1'b1;
          if (own_rsp_ready) begin
            to_pend_nxt = 1'b0;
            last_nxt    = owner;
            state_nxt   = IDLE;
          end
        end else begin
          rsp_valid       = s_icb_rsp_valid;
          rsp_rdata       = s_icb_rsp_rdata;
          s_icb_rsp_ready = own_rsp_ready;
          if (s_icb_rsp_valid && own_rsp_ready) begin
            last_nxt  = owner;
            state_nxt = IDLE;
          end else if (&timer) begin
            if (!s_icb_rsp_valid) begin
              to_pend_nxt = 1'b1;
            end
          end else begin
            timer_nxt = timer + TIMER_ONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Steer ready/response to the owner; the other master sees zeros.
  always_comb begin
    m0_icb_cmd_ready = cmd_ready & ~owner;
    m1_icb_cmd_ready = cmd_ready &  owner;
    m0_icb_rsp_valid = rsp_valid & ~owner;
    m1_icb_rsp_valid = rsp_valid &  owner;
    m0_icb_rsp_err   = rsp_err   & ~owner;
    m1_icb_rsp_err   = rsp_err   &  owner;
    m0_icb_rsp_rdata = owner ? 32'h0 : rsp_rdata;
    m1_icb_rsp_rdata = owner ? rsp_rdata : 32'h0;
  end

endmodule

// File: tb/tb_n101_uart_icb_arbiter.sv
// Directed bench for n101_uart_icb_arbiter: a cycle table for arbitration
// and routing, plus hand sequences for stall, timeout, backpressure and reset.
module tb_n101_uart_icb_arbiter;

  localparam logic [31:0] A0  = 32'h1000_0000;
  localparam logic [31:0] A1  = 32'h1000_0004;
  localparam logic [31:0] W0  = 32'h0000_0041;
  localparam logic [31:0] W1  = 32'h0000_0077;
  localparam logic [31:0] RD  = 32'h0000_0055;
  localparam logic [31:0] RD2 = 32'h0000_00A5;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk, rst_n;
  logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_read, m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
  logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_read, m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
  logic [31:0] m0_cmd_addr, m0_cmd_wdata, m0_rsp_rdata;
  logic [31:0] m1_cmd_addr, m1_cmd_wdata, m1_rsp_rdata;
  logic        s_cmd_valid, s_cmd_ready, s_cmd_read, s_rsp_valid, s_rsp_ready;
  logic [31:0] s_cmd_addr, s_cmd_wdata, s_rsp_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  n101_uart_icb_arbiter #(.AW(32), .TO_W(4), .ERR_DAT(32'hDEADBEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_icb_cmd_valid(m0_cmd_valid), .m0_icb_cmd_ready(m0_cmd_ready),
    .m0_icb_cmd_addr(m0_cmd_addr), .m0_icb_cmd_read(m0_cmd_read),
    .m0_icb_cmd_wdata(m0_cmd_wdata), .m0_icb_rsp_valid(m0_rsp_valid),
    .m0_icb_rsp_ready(m0_rsp_ready), .m0_icb_rsp_rdata(m0_rsp_rdata),
    .m0_icb_rsp_err(m0_rsp_err),
    .m1_icb_cmd_valid(m1_cmd_valid), .m1_icb_cmd_ready(m1_cmd_ready),
    .m1_icb_cmd_addr(m1_cmd_addr), .m1_icb_cmd_read(m1_cmd_read),
    .m1_icb_cmd_wdata(m1_cmd_wdata), .m1_icb_rsp_valid(m1_rsp_valid),
    .m1_icb_rsp_ready(m1_rsp_ready), .m1_icb_rsp_rdata(m1_rsp_rdata),
    .m1_icb_rsp_err(m1_rsp_err),
    .s_icb_cmd_valid(s_cmd_valid), .s_icb_cmd_ready(s_cmd_ready),
    .s_icb_cmd_addr(s_cmd_addr), .s_icb_cmd_read(s_cmd_read),
    .s_icb_cmd_wdata(s_cmd_wdata), .s_icb_rsp_valid(s_rsp_valid),
    .s_icb_rsp_ready(s_rsp_ready), .s_icb_rsp_rdata(s_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {s_cmd_valid, m0_cmd_ready, m1_cmd_ready, m0_rsp_valid,
  //        m1_rsp_valid, s_rsp_ready, m0_rsp_err, m1_rsp_err}
  typedef struct packed {
    logic [7:0]  ctl;
    logic [31:0] addr;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } obs_t;

  // in = {m0_cmd_valid, m1_cmd_valid, s_cmd_ready, s_rsp_valid, m0_rsp_ready, m1_rsp_ready}
  typedef struct packed {
    logic [5:0] in;
    obs_t       exp;
  } vec_t;

  vec_t vecs[$];

  function automatic obs_t mk(input logic [7:0] ctl, input logic [31:0] addr,
                              input logic [31:0] rd0, input logic [31:0] rd1);
    obs_t o;
    o.ctl = ctl; o.addr = addr; o.rd0 = rd0; o.rd1 = rd1;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk({s_cmd_valid, m0_cmd_ready, m1_cmd_ready, m0_rsp_valid,
               m1_rsp_valid, s_rsp_ready, m0_rsp_err, m1_rsp_err},
              s_cmd_addr, m0_rsp_rdata, m1_rsp_rdata);
  endfunction

  task automatic add(input logic [5:0] in, input logic [7:0] ctl, input logic [31:0] addr,
                     input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.in = in;
    v.exp = mk(ctl, addr, rd0, rd1);
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_obs(input string nm, input obs_t e);
    chk(nm, 128'(sample()), 128'(e));
  endtask

  task automatic drive(input logic [5:0] in);
    {m0_cmd_valid, m1_cmd_valid, s_cmd_ready, s_rsp_valid, m0_rsp_ready, m1_rsp_ready} = in;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    m0_cmd_addr = A0; m0_cmd_wdata = W0; m0_cmd_read = 1'b0;
    m1_cmd_addr = A1; m1_cmd_wdata = W1; m1_cmd_read = 1'b1;
    s_rsp_rdata = RD;
    rst_n = 1'b0;
    drive(6'b111111);

    // reset state: everything quiet even with all inputs active
    #3;  chk_obs("reset_early", mk(8'h00, 32'h0, 32'h0, 32'h0));
    chk("reset_cmd_data", {s_cmd_read, s_cmd_wdata}, 33'h0);
    #14; chk_obs("reset_after_edge", mk(8'h00, 32'h0, 32'h0, 32'h0));
    drive(6'b000000);
    #5;  rst_n = 1'b1;
    adv();

    // cycle table: round-robin, stalls, rsp backpressure, withdrawn request
    add(6'b111011, 8'b0000_0000, 32'h0, 32'h0, 32'h0); // IDLE, m0 wins (last=1)
    add(6'b111011, 8'b1100_0000, A0,    32'h0, 32'h0); // GRANT m0, handshake
    add(6'b111111, 8'b0001_0100, 32'h0, RD,    32'h0); // RSP m0
    add(6'b111011, 8'b0000_0000, 32'h0, 32'h0, 32'h0); // IDLE, m1 wins
    add(6'b111011, 8'b1010_0000, A1,    32'h0, 32'h0); // GRANT m1
    add(6'b111111, 8'b0000_1100, 32'h0, 32'h0, RD   ); // RSP m1
    add(6'b111011, 8'b0000_0000, 32'h0, 32'h0, 32'h0); // IDLE, m0 wins
    add(6'b110011, 8'b1000_0000, A0,    32'h0, 32'h0); // GRANT m0, slave stalls
    add(6'b111011, 8'b1100_0000, A0,    32'h0, 32'h0); // CMD m0, handshake
    add(6'b110011, 8'b0000_0100, 32'h0, RD,    32'h0); // RSP, no response yet
    add(6'b110101, 8'b0001_0000, 32'h0, RD,    32'h0); // RSP, m0 not ready
    add(6'b110111, 8'b0001_0100, 32'h0, RD,    32'h0); // RSP handshake
    add(6'b111011, 8'b0000_0000, 32'h0, 32'h0, 32'h0); // IDLE, m1 wins
    add(6'b101011, 8'b0010_0000, A1,    32'h0, 32'h0); // GRANT m1, m1 withdraws
    add(6'b111011, 8'b0000_0000, 32'h0, 32'h0, 32'h0); // IDLE, m1 still wins
    add(6'b111011, 8'b1010_0000, A1,    32'h0, 32'h0); // GRANT m1
    add(6'b111111, 8'b0000_1100, 32'h0, 32'h0, RD   ); // RSP m1
    add(6'b000000, 8'b0000_0000, 32'h0, 32'h0, 32'h0); // IDLE quiet
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in);
      settle();
      chk_obs($sformatf("vec%0d", i), vecs[i].exp);
      adv();
    end

    // m1 read held off by slave for 5 cycles; m0 blocked until m1 done
    drive(6'b010000);
    adv();                                    // now GRANT m1
    m0_cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("stall%0d", i), {s_cmd_valid, s_cmd_addr, s_cmd_read, s_cmd_wdata, m0_cmd_ready, m1_cmd_ready},
          {1'b1, A1, 1'b1, W1, 1'b0, 1'b0});
      adv();
    end
    s_cmd_ready = 1'b1;
    settle();
    chk("stall_release", {s_cmd_valid, m1_cmd_ready, m0_cmd_ready}, 3'b110);
    adv();                                    // RSP m1
    m1_cmd_valid = 1'b0; s_cmd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk($sformatf("m0_blocked%0d", i), {s_cmd_valid, m0_cmd_ready, m1_rsp_valid}, 3'b000);
      adv();
    end
    s_rsp_valid = 1'b1; m1_rsp_ready = 1'b1;
    settle();
    chk("m1_rsp", {m1_rsp_valid, m1_rsp_rdata, m0_rsp_valid}, {1'b1, RD, 1'b0});
    adv();                                    // IDLE, m0 requesting
    s_rsp_valid = 1'b0; m1_rsp_ready = 1'b0; s_cmd_ready = 1'b1;
    adv();                                    // GRANT m0
    settle();
    chk("m0_after_m1", {s_cmd_valid, s_cmd_addr, s_cmd_wdata, s_cmd_read, m0_cmd_ready}, {1'b1, A0, W0, 1'b0, 1'b1});
    adv();                                    // RSP m0
    drive(6'b000110);
    settle();
    chk("m0_write_rsp", {m0_rsp_valid, m0_rsp_err, m1_rsp_valid, m1_rsp_err}, 4'b1000);
    adv();

    // m0 read, UART silent: error response after the watchdog expires
    m0_cmd_read = 1'b1;
    drive(6'b101000);
    adv();                                    // GRANT m0, handshake this cycle
    settle();
    chk("to_cmd", {s_cmd_valid, s_cmd_read, s_cmd_addr}, {1'b1, 1'b1, A0});
    adv();                                    // RSP, timer=0
    m0_cmd_valid = 1'b0;
    n = 0;
    while (n < 40) begin
      settle();
      if (m0_rsp_valid) break;
      adv();
      n++;
    end
    // timer reaches 15 after 15 edges; to_pend is registered on the next one
    chk("to_latency", 128'(n), 128'(16));
    chk("to_rsp", {m0_rsp_valid, m0_rsp_rdata, m0_rsp_err, s_rsp_ready, m1_rsp_valid},
        {1'b1, ERR, 1'b1, 1'b1, 1'b0});
    adv();
    s_rsp_valid = 1'b1; s_rsp_rdata = RD2;    // late UART response is dropped
    for (int i = 0; i < 2; i++) begin
      settle();
      chk($sformatf("to_hold%0d", i), {m0_rsp_valid, m0_rsp_rdata, m0_rsp_err, s_rsp_ready},
          {1'b1, ERR, 1'b1, 1'b1});
      adv();
    end
    s_rsp_valid = 1'b0; m0_rsp_ready = 1'b1;
    adv();                                    // IDLE
    settle();
    chk("to_done", {m0_rsp_valid, m0_rsp_err, s_rsp_ready}, 3'b000);

    // m0 rsp_ready low 3 cycles: backpressure to UART, rdata stable, single rsp
    adv();
    m0_cmd_read = 1'b0;
    drive(6'b101000);
    adv();                                    // GRANT
    adv();                                    // RSP
    drive(6'b000100);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("bp%0d", i), {m0_rsp_valid, m0_rsp_rdata, s_rsp_ready}, {1'b1, RD2, 1'b0});
      adv();
    end
    m0_rsp_ready = 1'b1;
    settle();
    chk("bp_accept", {m0_rsp_valid, s_rsp_ready}, 2'b11);
    adv();
    settle();
    chk("bp_single", {m0_rsp_valid, s_rsp_ready}, 2'b00);

    // reset asserted mid-RSP, then a clean m1 grant
    adv();
    drive(6'b101000);
    adv();                                    // GRANT
    adv();                                    // RSP
    drive(6'b000011);
    settle();
    chk("pre_reset_rsp", {s_rsp_ready, m0_rsp_rdata}, {1'b1, RD2});
    #2 rst_n = 1'b0;
    #1 chk_obs("async_reset", mk(8'h00, 32'h0, 32'h0, 32'h0));
    settle();
    rst_n = 1'b1;
    drive(6'b011000);
    adv();                                    // GRANT m1
    settle();
    chk_obs("post_reset_grant", mk(8'b1010_0000, A1, 32'h0, 32'h0));
    adv();                                    // RSP m1
    drive(6'b000101);
    settle();
    chk("post_reset_rsp", {m1_rsp_valid, m1_rsp_rdata, m1_rsp_err, m0_rsp_valid}, {1'b1, RD2, 1'b0, 1'b0});
    adv();
    drive(6'b000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
